// File: rtl/csr_regfile_pkg.sv
// CSR addresses, write masks and reset values for the machine-mode CSR bank.
// The decode stage imports the same names so both sides agree on the address map.
package csr_regfile_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // MPP is hardwired to machine mode, so it lives in the fixed pattern, not in storage.
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;

  function automatic logic [31:0] csr_masked(input logic [31:0] value, input logic [31:0] mask);
    return value & mask;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// Free-running 64-bit cycle counter with independent load of each 32-bit half.
// Load takes effect at the next edge and suppresses that cycle's increment; no backpressure.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_lo,
  input  logic        load_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 64'd0;
    end else if (load_lo) begin
      count[31:0] <= wdata;
    end else if (load_hi) begin
      count[63:32] <= wdata;
    end else begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR bank with the 64-bit cycle counter; combinational read of addr.
// Writes commit on the rising edge after w_enable; no backpressure, unknown/RO writes dropped.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_enable,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [11:0] csr_addr;
  logic        unused_addr_hi;
  logic [31:0] mstatus_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [63:0] cycle_cnt;

  assign csr_addr       = addr[11:0];
  assign unused_addr_hi = ^addr[31:12];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_q  <= 32'd0;
      mie_q      <= 32'd0;
      mtvec_q    <= 32'd0;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
    end else if (w_enable) begin
      case (csr_addr)
        CSR_MSTATUS:  mstatus_q  <= csr_masked(wdata, MSTATUS_WMASK);
        CSR_MIE:      mie_q      <= csr_masked(wdata, MIE_WMASK);
        CSR_MTVEC:    mtvec_q    <= csr_masked(wdata, ALIGN4_MASK);
        CSR_MSCRATCH: mscratch_q <= wdata;
        CSR_MEPC:     mepc_q     <= csr_masked(wdata, ALIGN4_MASK);
        CSR_MCAUSE:   mcause_q   <= wdata;
        CSR_MTVAL:    mtval_q    <= wdata;
        default: ;
      endcase
    end
  end

  // Only the machine-mode aliases load the counter; the user-mode views are read-only.
  csr_counter64 u_counter (
    .clk     (clk),
    .rst     (rst),
    .load_lo (w_enable && (csr_addr == CSR_MCYCLE)),
    .load_hi (w_enable && (csr_addr == CSR_MCYCLEH)),
    .wdata   (wdata),
    .count   (cycle_cnt)
  );

  always_comb begin
    rdata = 32'd0;
    case (csr_addr)
      CSR_MSTATUS:                rdata = MSTATUS_FIXED | mstatus_q;
      CSR_MISA:                   rdata = MISA_VAL;
      CSR_MIE:                    rdata = mie_q;
      CSR_MTVEC:                  rdata = mtvec_q;
      CSR_MSCRATCH:               rdata = mscratch_q;
      CSR_MEPC:                   rdata = mepc_q;
      CSR_MCAUSE:                 rdata = mcause_q;
      CSR_MTVAL:                  rdata = mtval_q;
      CSR_MIP:                    rdata = 32'd0;
      CSR_MCYCLE,  CSR_CYCLE:     rdata = cycle_cnt[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:    rdata = cycle_cnt[63:32];
      CSR_MVENDORID, CSR_MARCHID,
      CSR_MIMPID:                 rdata = 32'd0;
      CSR_MHARTID:                rdata = HART_ID;
      default:                    rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Randomized bench for csr_regfile: a behavioural CSR model is compared every cycle,
// plus directed literal checks of reset, masking, read-only, carry and async reset.
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_enable = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  csr_regfile #(.HART_ID(32'd0), .MISA_VAL(32'h4000_0100)) dut (
    .clk      (clk),
    .rst      (rst),
    .w_enable (w_enable),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata)
  );

  always #5 clk = ~clk;

  // Architectural model: plain variables per CSR, written from the address-map rules.
  logic [31:0]     m_mstatus  = 32'd0;
  logic [31:0]     m_mie      = 32'd0;
  logic [31:0]     m_mtvec    = 32'd0;
  logic [31:0]     m_mscratch = 32'd0;
  logic [31:0]     m_mepc     = 32'd0;
  logic [31:0]     m_mcause   = 32'd0;
  logic [31:0]     m_mtval    = 32'd0;
  longint unsigned m_cyc      = 0;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [63:0] c;
    c = m_cyc;
    case (a[11:0])
      12'h300: return 32'h0000_1800 | m_mstatus;
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00, 12'hC00: return c[31:0];
      12'hB80, 12'hC80: return c[63:32];
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0;
    end else begin
      logic [63:0] c;
      c = m_cyc;
      if (w_enable && addr[11:0] == 12'hB00)      c = {c[63:32], wdata};
      else if (w_enable && addr[11:0] == 12'hB80) c = {wdata, c[31:0]};
      else                                         c = c + 64'd1;
      m_cyc = c;
      if (w_enable) begin
        case (addr[11:0])
          12'h300: m_mstatus  = wdata & 32'h0000_0088;
          12'h304: m_mie      = wdata & 32'h0000_0888;
          12'h305: m_mtvec    = {wdata[31:2], 2'b00};
          12'h340: m_mscratch = wdata;
          12'h341: m_mepc     = {wdata[31:2], 2'b00};
          12'h342: m_mcause   = wdata;
          12'h343: m_mtval    = wdata;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: addr=%h got %h expected %h at %0t", name, addr, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) chk("model", rdata, model_read(addr));
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
    @(posedge clk);
    #1;
    addr = a; w_enable = we; wdata = d;
  endtask

  task automatic wr_chk(input string name, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
    drive(a, 1'b1, d);
    drive(a, 1'b0, 32'd0);
    #1 chk(name, rdata, exp);
  endtask

  logic [11:0] addr_list [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hC00,
                                  12'hC80, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0,
                                  12'h000, 12'hFFF};

  initial begin
    logic [31:0] exp_c;
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] d;

    // Reset state, visible combinationally with no clock edge needed.
    #2 rst = 1'b0;
    #1 chk_en = 1'b1;
    addr = 32'h300; #1 chk("rst_mstatus", rdata, 32'h0000_1800);
    addr = 32'h305; #1 chk("rst_mtvec",   rdata, 32'h0);
    addr = 32'hB00; #1 chk("rst_mcycle",  rdata, 32'h0);
    addr = 32'h301; #1 chk("rst_misa",    rdata, 32'h4000_0100);
    addr = 32'hF14; #1 chk("rst_mhartid", rdata, 32'h0);
    @(negedge clk); #2 rst = 1'b1;

    // Same-cycle read returns the old value.
    drive(32'h340, 1'b1, 32'hDEAD_BEEF);
    #1 chk("mscratch_same_cycle", rdata, 32'h0);
    drive(32'h340, 1'b0, 32'h0);
    #1 chk("mscratch_next_cycle", rdata, 32'hDEAD_BEEF);

    // Field masks.
    wr_chk("mask_mstatus", 32'h300, 32'hFFFF_FFFF, 32'h0000_1888);
    wr_chk("mask_mie",     32'h304, 32'hFFFF_FFFF, 32'h0000_0888);
    wr_chk("mask_mtvec",   32'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
    wr_chk("mask_mepc",    32'h341, 32'h1234_5677, 32'h1234_5674);

    // Read-only and unimplemented.
    wr_chk("ro_misa",   32'h301, 32'h1234_5678, 32'h4000_0100);
    wr_chk("ro_mip",    32'h344, 32'hFFFF_FFFF, 32'h0);
    wr_chk("unimp_7c0", 32'h7C0, 32'h1234_5678, 32'h0);
    wr_chk("upper_addr_ignored", 32'hABCD_E340, 32'h0BAD_F00D, 32'h0BAD_F00D);
    drive(32'hC00, 1'b1, 32'h1234_5678);
    exp_c = 32'(m_cyc);
    #1 chk("cycle_write_read", rdata, exp_c);
    drive(32'hC00, 1'b0, 32'h0);
    #1 chk("cycle_keeps_counting", rdata, exp_c + 32'd1);

    // Carry from low to high word.
    drive(32'hB00, 1'b1, 32'hFFFF_FFFE);
    drive(32'hB80, 1'b1, 32'h0000_0005);
    drive(32'hB00, 1'b0, 32'h0);
    #1 chk("carry_lo_hold", rdata, 32'hFFFF_FFFE);
    addr = 32'hB80; #1 chk("carry_hi_loaded", rdata, 32'h5);
    drive(32'hB00, 1'b0, 32'h0);
    #1 chk("carry_lo_max", rdata, 32'hFFFF_FFFF);
    addr = 32'hB80; #1 chk("carry_hi_before", rdata, 32'h5);
    drive(32'hB80, 1'b0, 32'h0);
    #1 chk("carry_hi_after", rdata, 32'h6);
    addr = 32'hB00; #1 chk("carry_lo_wrap", rdata, 32'h0);
    addr = 32'hC80; #1 chk("carry_cycleh_alias", rdata, 32'h6);

    // Randomized traffic, with occasional async reset pulses and resets held across an edge.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      a = {20'd0, addr_list[$urandom_range(0, 19)]};
      if (r[0]) a[31:12] = r[31:12];
      if (r[1] && r[2]) a[11:0] = r[14:3];
      d = $urandom;
      if (a[11:0] == 12'hB00 && r[3]) d = 32'hFFFF_FFF0 | {28'd0, r[7:4]};
      if (a[11:0] == 12'hB80 && r[3]) d = 32'hFFFF_FFFF;
      drive(a, r[5] | r[6], d);
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b0;
        #4 rst = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        w_enable = 1'b1;
        #1 rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
      end
    end

    // Async reset mid-run clears state immediately.
    wr_chk("pre_reset_mscratch", 32'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    drive(32'hB00, 1'b0, 32'h0);
    #1 rst = 1'b0;
    #1 chk("async_rst_mcycle", rdata, 32'h0);
    addr = 32'h340; #1 chk("async_rst_mscratch", rdata, 32'h0);
    @(negedge clk);
    addr = 32'h300; #1 chk("async_rst_mstatus", rdata, 32'h0000_1800);
    #1 rst = 1'b1;
    drive(32'hB00, 1'b0, 32'h0);
    drive(32'hB00, 1'b0, 32'h0);
    #1 chk("count_after_reset", rdata, 32'd2);

    @(negedge clk);
    #1 chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
